set_read_port: RTL and testbench
================================

SET_READ_PORT -- requirements
Module: set_read_port

Interface
REQ-001 Parameter NUM_BLOCKS, default 4, number of 512-bit blocks in the set.
REQ-002 Parameter LINE_BITS, default 512, block width in bits (64 bytes).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  read request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_block  input  2  block number within set.
REQ-008 req_offset  input  6  byte offset within block.
REQ-009 req_size  input  2  read size: 0=8, 1=16, 2=32, 3=64 bits.
REQ-010 req_signed  input  1  1 = sign-extend result to 64 bits, 0 = zero-extend.
REQ-011 bank_rd_en  output  1  one-cycle read strobe to set storage.
REQ-012 bank_rd_block  output  2  block index presented with bank_rd_en.
REQ-013 bank_rd_data  input  LINE_BITS  block contents, valid exactly one cycle after bank_rd_en.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_data  output  64  extracted, extended read data.
REQ-017 rsp_err  output  1  request crossed block boundary; rsp_data is 0.
REQ-018 read_count  output  16  completed non-error responses, saturating.

Function
REQ-019 FSM states IDLE, FETCH, WAIT, EXTRACT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: on req_valid, latch block/offset/size/signed; if offset + 2^size > 64, go to RESP with rsp_err=1, else go to FETCH.
REQ-021 FETCH: assert bank_rd_en=1 for exactly one cycle with bank_rd_block = latched block; go to WAIT.
REQ-022 WAIT: capture bank_rd_data into an internal LINE_BITS register at end of cycle; go to EXTRACT.
REQ-023 EXTRACT: start = 512 - 8*2^size - 8*offset; field = line[start + 8*2^size - 1 : start]; byte offset 0 maps to bits 511:504 (matching the set write path).
REQ-024 EXTRACT: rsp_data = field zero-extended, or sign-extended from field MSB when signed=1; go to RESP.
REQ-025 RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_valid && rsp_ready; then return to IDLE.
REQ-026 Latency, error-free request accepted in cycle N: bank_rd_en in N+1, rsp_valid first high in N+4.
REQ-027 Error latency: rsp_valid first high in N+1; no bank_rd_en is issued.
REQ-028 read_count increments by 1 on each accepted handshake with rsp_err=0; holds at 16'hFFFF.
REQ-029 New request SHALL NOT be accepted in the cycle a response handshakes (back-to-back minimum 1 IDLE cycle).
REQ-030 req_size=3 with offset 56 is legal (exact fit); offset 57 with size 3 is an error.
REQ-031 Request inputs are ignored outside IDLE; changes after acceptance do not affect the response.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, req_ready=1, bank_rd_en=0, rsp_valid=0, rsp_data=0, rsp_err=0, read_count=0, line register=0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no response; first request after release behaves as from cold reset.

Verification
REQ-034 Line = bytes 0x00..0x3F at offsets 0..63; read block 1, offset 0, size 0, unsigned -> rsp_data=0x00, bank_rd_en in N+1, rsp_valid in N+4, read_count=1.
REQ-035 Same line; offset 4, size 2 -> rsp_data=0x0000000004050607; offset 56, size 3 -> 0x38393A3B3C3D3E3F.
REQ-036 Byte 10 = 0x80; offset 10, size 0, signed=1 -> 0xFFFFFFFFFFFFFF80; signed=0 -> 0x0000000000000080.
REQ-037 offset 62, size 2 -> rsp_err=1, rsp_data=0, no bank_rd_en, rsp_valid in N+1, read_count unchanged.
REQ-038 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable; req_ready=0 throughout; completes on rsp_ready=1.
REQ-039 rst_n pulsed low in WAIT -> outputs at reset values asynchronously, no response issued; next request returns correct data.

Source files
------------

// File: rtl/set_read_port_if.sv
// set_read_port_if: request, bank-read and response signals between a set
// read port and its requester/storage.
interface set_read_port_if #(
  parameter int NUM_BLOCKS = 4,
  parameter int LINE_BITS  = 512
);
  localparam int BLK_W = $clog2(NUM_BLOCKS);
  logic                 req_valid;
  logic                 req_ready;
  logic [BLK_W-1:0]     req_block;
  logic [5:0]           req_offset;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic                 bank_rd_en;
  logic [BLK_W-1:0]     bank_rd_block;
  logic [LINE_BITS-1:0] bank_rd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [63:0]          rsp_data;
  logic                 rsp_err;
  logic [15:0]          read_count;
  modport slave (
    input  req_valid, req_block, req_offset, req_size, req_signed, bank_rd_data, rsp_ready,
    output req_ready, bank_rd_en, bank_rd_block, rsp_valid, rsp_data, rsp_err, read_count
  );
  modport master (
    output req_valid, req_block, req_offset, req_size, req_signed, bank_rd_data, rsp_ready,
    input  req_ready, bank_rd_en, bank_rd_block, rsp_valid, rsp_data, rsp_err, read_count
  );
endinterface

// File: rtl/set_read_port.sv
// set_read_port: fetches one block of a set, extracts an 8/16/32/64-bit field at a
// byte offset (byte 0 in the line MSBs) and returns it zero- or sign-extended.
module set_read_port #(
  parameter int NUM_BLOCKS = 4,
  parameter int LINE_BITS  = 512
) (
  input logic clk,
  input logic rst_n,
  set_read_port_if.slave bus
);
  localparam int BLK_W = $clog2(NUM_BLOCKS);
  localparam int PAD_W = LINE_BITS + 64;
  localparam int IDX_W = $clog2(PAD_W);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXTRACT, RESP} state_t;
  state_t               state_q, state_d;
  logic [BLK_W-1:0]     blk_q, blk_d;
  logic [5:0]           off_q, off_d;
  logic [1:0]           size_q, size_d;
  logic                 sgn_q, sgn_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [63:0]          data_q, data_d;
  logic                 err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 too_big;
  logic [PAD_W-1:0]     pad;
  logic [IDX_W-1:0]     idx;
  logic [63:0]          top, zx, sx, ext;
  assign too_big = ({1'b0, bus.req_offset} + (7'd1 << bus.req_size)) > 7'd64;
  // Zero padding below the line keeps the 64-bit window in range for offsets past 56.
  assign pad = {line_q, 64'b0};
  assign idx = IDX_W'(PAD_W - 1) - IDX_W'({off_q, 3'b000});
  assign top = pad[idx -: 64];
  assign zx  = size_q == 2'd0 ? {56'b0, top[63:56]} :
               size_q == 2'd1 ? {48'b0, top[63:48]} :
               size_q == 2'd2 ? {32'b0, top[63:32]} : top;
  assign sx  = size_q == 2'd0 ? {{56{top[63]}}, top[63:56]} :
               size_q == 2'd1 ? {{48{top[63]}}, top[63:48]} :
               size_q == 2'd2 ? {{32{top[63]}}, top[63:32]} : top;
  assign ext = sgn_q ? sx : zx;
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    line_d  = line_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        blk_d   = bus.req_block;
        off_d   = bus.req_offset;
        size_d  = bus.req_size;
        sgn_d   = bus.req_signed;
        err_d   = too_big;
        data_d  = '0;
        state_d = too_big ? RESP : FETCH;
      end
      FETCH:   state_d = WAIT;
      WAIT: begin
        line_d  = bus.bank_rd_data;
        state_d = EXTRACT;
      end
      EXTRACT: begin
        data_d  = ext;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        cnt_d   = (!err_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      line_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      line_q  <= line_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.req_ready     = state_q == IDLE;
  assign bus.bank_rd_en    = state_q == FETCH;
  assign bus.bank_rd_block = blk_q;
  assign bus.rsp_valid     = state_q == RESP;
  assign bus.rsp_data      = data_q;
  assign bus.rsp_err       = err_q;
  assign bus.read_count    = cnt_q;
endmodule

// File: tb/tb_set_read_port.sv
// tb_set_read_port: directed reads against a four-line storage model with
// hand-computed field values, latencies, error cases and a mid-transaction reset.
module tb_set_read_port;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  set_read_port_if bus ();
  set_read_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [511:0] mem [4];
  always @(posedge clk) if (bus.bank_rd_en) bus.bank_rd_data <= mem[bus.bank_rd_block];
  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_read(input logic [1:0] blk, input logic [5:0] off, input logic [1:0] sz,
                         input logic sg, input logic [63:0] exp_d, input logic exp_e, input int hold);
    int lat, en_n, en_at;
    logic [1:0] en_blk;
    logic [63:0] d0;
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_block = blk; bus.req_offset = off; bus.req_size = sz; bus.req_signed = sg;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_block = ~blk; bus.req_offset = ~off; bus.req_size = ~sz; bus.req_signed = ~sg;
    lat = 1; en_n = 0; en_at = 0; en_blk = 2'd0;
    while (1) begin
      if (bus.bank_rd_en) begin en_n++; en_at = lat; en_blk = bus.bank_rd_block; end
      if (bus.rsp_valid || lat >= 20) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 64'(lat), exp_e ? 64'd1 : 64'd4);
    chk("bank_rd_en_count", 64'(en_n), exp_e ? 64'd0 : 64'd1);
    if (!exp_e) begin
      chk("bank_rd_en_cycle", 64'(en_at), 64'd1);
      chk("bank_rd_block", 64'(en_blk), 64'(blk));
    end
    chk("rsp_data", bus.rsp_data, exp_d);
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_e));
    d0 = bus.rsp_data;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rsp_data", bus.rsp_data, d0);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    chk("no_accept_on_handshake", 64'(bus.req_ready), 64'd1);
    if (!exp_e) exp_cnt++;
    chk("read_count", 64'(bus.read_count), 64'(exp_cnt));
  endtask
  initial begin
    logic [511:0] l0, l1, l2, l3;
    for (int i = 0; i < 64; i++) begin
      l0[511-8*i -: 8] = 8'(i) ^ 8'h55;
      l1[511-8*i -: 8] = 8'(i);
      l3[511-8*i -: 8] = 8'(i) + 8'hC0;
    end
    l2 = l1;
    l2[511-80 -: 8] = 8'h80;
    mem[0] = l0; mem[1] = l1; mem[2] = l2; mem[3] = l3;
    bus.req_valid = 1'b0; bus.req_block = '0; bus.req_offset = '0; bus.req_size = '0;
    bus.req_signed = 1'b0; bus.rsp_ready = 1'b0; bus.bank_rd_data = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_bank_rd_en", 64'(bus.bank_rd_en), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_read_count", 64'(bus.read_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_read(2'd1, 6'd0,  2'd0, 1'b0, 64'h0000000000000000, 1'b0, 0);
    do_read(2'd1, 6'd4,  2'd2, 1'b0, 64'h0000000004050607, 1'b0, 0);
    do_read(2'd1, 6'd56, 2'd3, 1'b0, 64'h38393A3B3C3D3E3F, 1'b0, 0);
    do_read(2'd2, 6'd10, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0, 0);
    do_read(2'd2, 6'd10, 2'd0, 1'b0, 64'h0000000000000080, 1'b0, 0);
    do_read(2'd1, 6'd62, 2'd2, 1'b0, 64'h0000000000000000, 1'b1, 0);
    do_read(2'd1, 6'd57, 2'd3, 1'b1, 64'h0000000000000000, 1'b1, 0);
    do_read(2'd1, 6'd63, 2'd0, 1'b0, 64'h000000000000003F, 1'b0, 0);
    do_read(2'd3, 6'd0,  2'd1, 1'b1, 64'hFFFFFFFFFFFFC0C1, 1'b0, 0);
    do_read(2'd3, 6'd4,  2'd2, 1'b1, 64'hFFFFFFFFC4C5C6C7, 1'b0, 0);
    do_read(2'd0, 6'd0,  2'd3, 1'b0, 64'h5554575651505352, 1'b0, 0);
    do_read(2'd1, 6'd8,  2'd1, 1'b0, 64'h0000000000000809, 1'b0, 5);
    do_read(2'd3, 6'd60, 2'd2, 1'b0, 64'h00000000FCFDFEFF, 1'b0, 0);
    @(negedge clk);
    bus.req_block = 2'd1; bus.req_offset = 6'd4; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("mid_rst_bank_rd_en", 64'(bus.bank_rd_en), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_rsp_data", bus.rsp_data, 64'd0);
    chk("mid_rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("mid_rst_read_count", 64'(bus.read_count), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no_rsp_after_abort", 64'(bus.rsp_valid), 64'd0);
    end
    do_read(2'd1, 6'd4, 2'd2, 1'b0, 64'h0000000004050607, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
